// File: rtl/alu_controller_if.sv
// alu_controller_if
//  Bundles the instruction handshake, the ALU flag input and the decoded
//  datapath controls that pass between the controller and its neighbours.
//  master : instruction source / datapath side (drives instr, instr_valid,
//           Flags_in; observes everything else)
//  slave  : alu_controller
//  Signals:
//   instr_valid  1      instr holds a valid instruction
//   instr        16     instruction word
//   instr_ready  1      controller accepts instr this cycle
//   Flags_in     5      combinational ALU flags from the datapath
//   wEnable      16     one-hot register write enable (Rdest)
//   opcode       8      ALU opcode
//   Rdest_select 4      Rdest mux select
//   Rsrc_select  4      Rsrc mux select
//   Imm_select   1      1 = ALU B operand is Imm_in
//   Imm_in       16     extended immediate
//   flags_q      5      flags latched from the last flag-writing instruction
//   retired      CNT_W  retired-instruction count (wraps)
//   halted       1      controller is halted
interface alu_controller_if #(
   parameter int CNT_W = 16
);
   logic             instr_valid;
   logic [15:0]      instr;
   logic             instr_ready;
   logic [4:0]       Flags_in;
   logic [15:0]      wEnable;
   logic [7:0]       opcode;
   logic [3:0]       Rdest_select;
   logic [3:0]       Rsrc_select;
   logic             Imm_select;
   logic [15:0]      Imm_in;
   logic [4:0]       flags_q;
   logic [CNT_W-1:0] retired;
   logic             halted;

   modport master (
      output instr_valid, instr, Flags_in,
      input  instr_ready, wEnable, opcode, Rdest_select, Rsrc_select,
             Imm_select, Imm_in, flags_q, retired, halted
   );

   modport slave (
      input  instr_valid, instr, Flags_in,
      output instr_ready, wEnable, opcode, Rdest_select, Rsrc_select,
             Imm_select, Imm_in, flags_q, retired, halted
   );
endinterface

// File: rtl/alu_controller.sv
// alu_controller
//  Control FSM in front of the register-bank/ALU datapath. Takes 16-bit
//  instructions over a valid/ready handshake, holds the current one in IR,
//  decodes IR into opcode, register selects, immediate and a one-hot write
//  enable, latches the ALU flags and counts retired instructions.
//  Ports:
//   clk    clock, all state changes on the rising edge
//   reset  asynchronous active-high reset
//   bus    alu_controller_if.slave (handshake, flags, datapath controls)
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_FETCH | ready for an instruction; HALT_WORD goes to ST_HALT
//  ST_EXEC  | one cycle, write enable asserted, flags/counter update at end
//  ST_HALT  | stopped; only reset leaves this state
module alu_controller #(
   parameter logic [15:0] HALT_WORD = 16'hFFFF,
   parameter int          CNT_W     = 16
) (
   input  logic            clk,
   input  logic            reset,
   alu_controller_if.slave bus
);

   localparam logic [1:0] ST_FETCH = 2'b00;
   localparam logic [1:0] ST_EXEC  = 2'b01;
   localparam logic [1:0] ST_HALT  = 2'b10;

   localparam logic [3:0] OP_CMP = 4'hB;

   logic [1:0]       state_q;
   logic [15:0]      ir_q;
   logic [4:0]       flags_q;
   logic [CNT_W-1:0] retired_q;

   logic [3:0]  ir_class;
   logic [3:0]  ir_rdest;
   logic [3:0]  ir_funct;
   logic [3:0]  ir_rsrc;
   logic        reg_form;
   logic        logical_imm;
   logic        is_nop;
   logic        is_cmp;
   logic        no_write;

   logic [7:0]  opcode_d;
   logic        imm_select_d;
   logic [15:0] imm_in_d;
   logic [15:0] wen_d;

   // ------------------------------------------------------------------
   // Decode: purely from IR, so the datapath controls stay stable in every
   // state and change only when a new instruction is latched.
   // ------------------------------------------------------------------
   assign ir_class = ir_q[15:12];
   assign ir_rdest = ir_q[11:8];
   assign ir_funct = ir_q[7:4];
   assign ir_rsrc  = ir_q[3:0];

   assign reg_form    = (ir_class == 4'h0);
   assign logical_imm = (ir_class == 4'h1) || (ir_class == 4'h2) || (ir_class == 4'h3);
   assign is_nop      = (ir_q == 16'h0000);
   assign is_cmp      = (reg_form && (ir_funct == OP_CMP)) || (ir_class == OP_CMP);
   assign no_write    = is_nop || is_cmp;

   always_comb begin
      opcode_d     = 8'h00;
      imm_select_d = 1'b0;
      imm_in_d     = 16'h0000;
      if (reg_form) begin
         opcode_d = {4'h0, ir_funct};
      end else begin
         opcode_d     = {ir_class, 4'h0};
         imm_select_d = 1'b1;
         if (logical_imm) begin
            imm_in_d = {8'h00, ir_q[7:0]};
         end else begin
            imm_in_d = {{8{ir_q[7]}}, ir_q[7:0]};
         end
      end
   end

   // The write enable is decoded from the state register, which reset clears
   // asynchronously, so a reset during EXEC drops the write in the same cycle.
   always_comb begin
      wen_d = 16'h0000;
      if ((state_q == ST_EXEC) && !no_write) begin
         wen_d = 16'h0001 << ir_rdest;
      end
   end

   // ------------------------------------------------------------------
   // Sequencer
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_FETCH;
         ir_q      <= 16'h0000;
         flags_q   <= 5'b00000;
         retired_q <= '0;
      end else begin
         case (state_q)
            ST_FETCH: begin
               if (bus.instr_valid) begin
                  // The halt word is caught before it can be latched, so IR
                  // (and the decoded outputs) keep the last real instruction.
                  if (bus.instr == HALT_WORD) begin
                     state_q <= ST_HALT;
                  end else begin
                     ir_q    <= bus.instr;
                     state_q <= ST_EXEC;
                  end
               end
            end
            ST_EXEC: begin
               if (!is_nop) begin
                  flags_q <= bus.Flags_in;
               end
               retired_q <= retired_q + CNT_W'(1);
               state_q   <= ST_FETCH;
            end
            ST_HALT: begin
               state_q <= ST_HALT;
            end
            default: begin
               state_q <= ST_FETCH;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.instr_ready  = (state_q == ST_FETCH);
   assign bus.halted       = (state_q == ST_HALT);
   assign bus.wEnable      = wen_d;
   assign bus.opcode       = opcode_d;
   assign bus.Rdest_select = ir_rdest;
   assign bus.Rsrc_select  = ir_rsrc;
   assign bus.Imm_select   = imm_select_d;
   assign bus.Imm_in       = imm_in_d;
   assign bus.flags_q      = flags_q;
   assign bus.retired      = retired_q;

endmodule

// File: tb/tb_alu_controller.sv
module tb_alu_controller;

   logic clk;
   logic reset;

   int n_checks;
   int n_errors;

   logic [15:0] exp_ret;
   logic [4:0]  exp_flags;
   logic [7:0]  last_op;

   alu_controller_if #(.CNT_W(16)) bus ();
   alu_controller_if #(.CNT_W(3))  bus_w ();

   alu_controller #(.HALT_WORD(16'hFFFF), .CNT_W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   alu_controller #(.HALT_WORD(16'hFFFF), .CNT_W(3)) dut_w (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_w.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one instruction from FETCH, check the EXEC-cycle controls, then
   // check the state back in FETCH.
   task automatic run_instr(input logic [15:0] word, input logic [4:0] flg,
                            input logic [15:0] e_wen, input logic [7:0] e_op,
                            input logic e_isel, input logic [15:0] e_imm,
                            input logic upd_flags);
      chk("ready_fetch", 32'(bus.instr_ready), 32'd1);
      bus.instr       = word;
      bus.instr_valid = 1'b1;
      bus.Flags_in    = flg;
      tick();
      bus.instr_valid = 1'b0;
      chk("ready_exec", 32'(bus.instr_ready), 32'd0);
      chk("wen_exec", 32'(bus.wEnable), 32'(e_wen));
      chk("opcode", 32'(bus.opcode), 32'(e_op));
      chk("rdest", 32'(bus.Rdest_select), 32'(word[11:8]));
      chk("rsrc", 32'(bus.Rsrc_select), 32'(word[3:0]));
      chk("imm_sel", 32'(bus.Imm_select), 32'(e_isel));
      chk("imm_in", 32'(bus.Imm_in), 32'(e_imm));
      tick();
      exp_ret = exp_ret + 16'd1;
      if (upd_flags) exp_flags = flg;
      last_op = e_op;
      chk("ready_back", 32'(bus.instr_ready), 32'd1);
      chk("wen_fetch", 32'(bus.wEnable), 32'd0);
      chk("flags_q", 32'(bus.flags_q), 32'(exp_flags));
      chk("retired", 32'(bus.retired), 32'(exp_ret));
      chk("opcode_hold", 32'(bus.opcode), 32'(e_op));
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      exp_ret   = 16'd0;
      exp_flags = 5'd0;
      last_op   = 8'h00;

      bus.instr_valid   = 1'b0;
      bus.instr         = 16'h0000;
      bus.Flags_in      = 5'd0;
      bus_w.instr_valid = 1'b0;
      bus_w.instr       = 16'h0000;
      bus_w.Flags_in    = 5'd0;

      reset = 1'b1;
      tick();
      tick();

      // Reset state
      chk("rst_ready", 32'(bus.instr_ready), 32'd1);
      chk("rst_wen", 32'(bus.wEnable), 32'd0);
      chk("rst_halted", 32'(bus.halted), 32'd0);
      chk("rst_retired", 32'(bus.retired), 32'd0);
      chk("rst_flags", 32'(bus.flags_q), 32'd0);
      chk("rst_opcode", 32'(bus.opcode), 32'd0);
      chk("rst_imm", 32'(bus.Imm_in), 32'd0);
      chk("rst_isel", 32'(bus.Imm_select), 32'd0);
      chk("rst_sel", 32'({bus.Rdest_select, bus.Rsrc_select}), 32'd0);
      reset = 1'b0;
      tick();

      // Reset in the middle of EXEC aborts the write
      bus.instr       = 16'h0153;
      bus.instr_valid = 1'b1;
      bus.Flags_in    = 5'b11111;
      tick();
      bus.instr_valid = 1'b0;
      chk("abort_wen_pre", 32'(bus.wEnable), 32'h0002);
      #2;
      reset = 1'b1;
      #1;
      chk("abort_wen", 32'(bus.wEnable), 32'd0);
      chk("abort_ready", 32'(bus.instr_ready), 32'd1);
      tick();
      reset = 1'b0;
      tick();
      chk("abort_retired", 32'(bus.retired), 32'd0);
      chk("abort_flags", 32'(bus.flags_q), 32'd0);
      chk("abort_opcode", 32'(bus.opcode), 32'd0);
      chk("abort_ready2", 32'(bus.instr_ready), 32'd1);

      // Register and immediate forms
      run_instr(16'h0153, 5'b00011, 16'h0002, 8'h05, 1'b0, 16'h0000, 1'b1);
      run_instr(16'h52FF, 5'b01000, 16'h0004, 8'h50, 1'b1, 16'hFFFF, 1'b1);
      run_instr(16'h12FF, 5'b00001, 16'h0004, 8'h10, 1'b1, 16'h00FF, 1'b1);
      run_instr(16'h3480, 5'b00110, 16'h0010, 8'h30, 1'b1, 16'h0080, 1'b1);
      run_instr(16'h4480, 5'b00100, 16'h0010, 8'h40, 1'b1, 16'hFF80, 1'b1);
      run_instr(16'h0F21, 5'b00010, 16'h8000, 8'h02, 1'b0, 16'h0000, 1'b1);

      // No-write instructions
      run_instr(16'h0BB4, 5'b10101, 16'h0000, 8'h0B, 1'b0, 16'h0000, 1'b1);
      run_instr(16'hB705, 5'b01010, 16'h0000, 8'hB0, 1'b1, 16'h0005, 1'b1);
      run_instr(16'h0000, 5'b11111, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b0);
      run_instr(16'h0653, 5'b11001, 16'h0040, 8'h05, 1'b0, 16'h0000, 1'b1);

      // Halt: never executes, ignores later instructions until reset
      bus.instr       = 16'hFFFF;
      bus.instr_valid = 1'b1;
      tick();
      chk("halt_halted", 32'(bus.halted), 32'd1);
      chk("halt_ready", 32'(bus.instr_ready), 32'd0);
      chk("halt_opcode", 32'(bus.opcode), 32'(last_op));
      chk("halt_rdest", 32'(bus.Rdest_select), 32'h6);
      for (int i = 0; i < 12; i++) begin
         bus.instr = 16'h0153 + 16'(i * 16'h0100);
         tick();
         chk("halt_hold_ready", 32'(bus.instr_ready), 32'd0);
         chk("halt_hold_wen", 32'(bus.wEnable), 32'd0);
         chk("halt_hold_halted", 32'(bus.halted), 32'd1);
      end
      bus.instr_valid = 1'b0;
      chk("halt_retired", 32'(bus.retired), 32'(exp_ret));
      chk("halt_flags", 32'(bus.flags_q), 32'(exp_flags));
      reset = 1'b1;
      #1;
      chk("halt_rst_halted", 32'(bus.halted), 32'd0);
      chk("halt_rst_ready", 32'(bus.instr_ready), 32'd1);
      tick();
      reset = 1'b0;
      tick();
      chk("halt_rst_retired", 32'(bus.retired), 32'd0);

      // Back-to-back with valid held high on a 3-bit counter instance:
      // ready toggles 1,0,1,0 and the count wraps after 8 instructions.
      bus_w.instr_valid = 1'b1;
      for (int i = 0; i < 9; i++) begin
         chk("b2b_ready_fetch", 32'(bus_w.instr_ready), 32'd1);
         bus_w.instr = {4'h0, 4'(i), 4'h1, 4'h0};
         tick();
         chk("b2b_ready_exec", 32'(bus_w.instr_ready), 32'd0);
         chk("b2b_wen", 32'(bus_w.wEnable), 32'(16'h0001 << i));
         bus_w.instr = 16'h0F00;
         tick();
         chk("b2b_rdest_hold", 32'(bus_w.Rdest_select), 32'(i));
         chk("b2b_retired", 32'(bus_w.retired), 32'((i + 1) % 8));
      end
      bus_w.instr_valid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
